// File: rtl/iob_cache_arbiter_if.sv
// iob native bundle between N_PORTS requesters, the arbiter and the cache front-end.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface iob_cache_arbiter_if #(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  logic [N_PORTS-1:0]            s_valid;
  logic [N_PORTS*ADDR_W-1:0]     s_addr;
  logic [N_PORTS*DATA_W-1:0]     s_wdata;
  logic [N_PORTS*DATA_W/8-1:0]   s_wstrb;
  logic [N_PORTS-1:0]            s_ready;
  logic [DATA_W-1:0]             s_rdata;
  logic                          m_valid;
  logic [ADDR_W-1:0]             m_addr;
  logic [DATA_W-1:0]             m_wdata;
  logic [DATA_W/8-1:0]           m_wstrb;
  logic                          m_ready;
  logic [DATA_W-1:0]             m_rdata;

  modport slave (
    input  s_valid, s_addr, s_wdata, s_wstrb, m_ready, m_rdata,
    output s_ready, s_rdata, m_valid, m_addr, m_wdata, m_wstrb
  );

  modport master (
    output s_valid, s_addr, s_wdata, s_wstrb, m_ready, m_rdata,
    input  s_ready, s_rdata, m_valid, m_addr, m_wdata, m_wstrb
  );
endinterface

// File: rtl/iob_cache_arbiter.sv
// Shares one iob native cache front-end port among N_PORTS requesters, grant locked until m_ready.
// Round-robin by default; define IOB_CACHE_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
module iob_cache_arbiter #(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int ID_W    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic               clk,
  input  logic               resetn,
  iob_cache_arbiter_if.slave bus,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic [ID_W-1:0] pick;
  logic            found;
  logic            fire;

  logic [N_PORTS-1:0][ADDR_W-1:0] addr_a;
  logic [N_PORTS-1:0][DATA_W-1:0] wdata_a;
  logic [N_PORTS-1:0][STRB_W-1:0] wstrb_a;

  assign addr_a  = bus.s_addr;
  assign wdata_a = bus.s_wdata;
  assign wstrb_a = bus.s_wstrb;

  assign fire = (state_q == BUSY) && bus.m_ready;

`ifdef IOB_CACHE_ARB_FIXED_PRIO_EN
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (!found && bus.s_valid[i]) begin
        found = 1'b1;
        pick  = ID_W'(i);
      end
    end
  end
`else
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  // First pass covers ports at or above the pointer, second pass the wrapped-around ones.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (!found && bus.s_valid[i] && (ID_W'(i) >= rr_ptr_q)) begin
        found = 1'b1;
        pick  = ID_W'(i);
      end
    end
    for (int i = 0; i < N_PORTS; i++) begin
      if (!found && bus.s_valid[i]) begin
        found = 1'b1;
        pick  = ID_W'(i);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (fire)
      rr_ptr_d = (grant_id_q == ID_W'(N_PORTS - 1)) ? '0 : grant_id_q + ID_W'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rr_ptr_q <= '0;
    else         rr_ptr_q <= rr_ptr_d;
  end
`endif

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = BUSY;
          grant_id_d = pick;
        end
      end
      BUSY: begin
        if (bus.m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign bus.m_valid = (state_q == BUSY);
  assign busy        = (state_q == BUSY);
  assign grant_id    = grant_id_q;
  assign bus.m_addr  = addr_a[grant_id_q];
  assign bus.m_wdata = wdata_a[grant_id_q];
  assign bus.m_wstrb = wstrb_a[grant_id_q];
  assign bus.s_rdata = bus.m_rdata;

  for (genvar i = 0; i < N_PORTS; i++) begin : g_ready
    assign bus.s_ready[i] = fire && (grant_id_q == ID_W'(i));
  end
endmodule
